// File: rtl/spart_pkg.sv
// Shared types and constants for the SPART receive/transmit paths.
package spart_pkg;

  // Receiver frame-tracking states.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } rx_state_t;

  // Ticks per bit period and the tick count at which the start bit is checked.
  localparam int OVERSAMPLE = 16;
  localparam int MID_SAMPLE = OVERSAMPLE / 2 - 1;

  // Default baud divisors for the driver's br_cfg encodings, assuming a
  // 100 MHz system clock: divisor = clk / (OVERSAMPLE * baud) - 1.
  localparam logic [15:0] DIV_4800  = 16'd1301;
  localparam logic [15:0] DIV_9600  = 16'd650;
  localparam logic [15:0] DIV_19200 = 16'd325;
  localparam logic [15:0] DIV_38400 = 16'd162;

  // Map a br_cfg encoding onto its default divisor.
  function automatic logic [15:0] br_divisor(input logic [1:0] br_cfg);
    case (br_cfg)
      2'b00:   br_divisor = DIV_4800;
      2'b01:   br_divisor = DIV_9600;
      2'b10:   br_divisor = DIV_19200;
      default: br_divisor = DIV_38400;
    endcase
  endfunction

endpackage

// File: rtl/spart_rx_if.sv
// Bus-side connection between the SPART bus interface and the receiver.
interface spart_rx_if #(
  parameter int DIV_W = 16
);

  logic [DIV_W-1:0] divisor;
  logic             rd_ack;
  logic [7:0]       rx_data;
  logic             rda;
  logic             frame_err;
  logic             overrun;

  // Bus interface side: supplies the divisor and read acknowledge.
  modport master (
    output divisor,
    output rd_ack,
    input  rx_data,
    input  rda,
    input  frame_err,
    input  overrun
  );

  // Receiver side: returns the byte and status.
  modport slave (
    input  divisor,
    input  rd_ack,
    output rx_data,
    output rda,
    output frame_err,
    output overrun
  );

endinterface

// File: rtl/spart_baud_tick.sv
// Oversampling tick generator: one-cycle tick every divisor+1 clocks.
module spart_baud_tick #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DIV_W-1:0] divisor,
  input  logic             realign,
  output logic             tick
);

  logic [DIV_W-1:0] cnt_q;
  logic [DIV_W-1:0] cnt_d;

  // Count down; reload on expiry, or early when the user wants to restart the phase.
  always_comb begin
    cnt_d = cnt_q - DIV_W'(1);
    if (realign || (cnt_q == '0)) begin
      cnt_d = divisor;
    end
  end

  // Counter register; reset loads the current divisor.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= divisor;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = (cnt_q == '0);

endmodule

// File: rtl/spart_rx.sv
// SPART receiver: 16x oversampled 8N1 deserialiser with sticky status.
module spart_rx
  import spart_pkg::*;
#(
  parameter int OVERSAMPLE = 16,
  parameter int DIV_W      = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd,
  spart_rx_if.slave  bus
);

  // Last tick count in a bit, and the count just before the start-bit check
  // (the check fires on the tick that brings scnt up to the mid-bit value).
  localparam logic [3:0] LAST_CNT = 4'(OVERSAMPLE - 1);
  localparam logic [3:0] PRE_MID  = 4'(OVERSAMPLE / 2 - 2);

  rx_state_t state_q, state_d;

  logic [1:0] sync_q, sync_d;
  logic [3:0] scnt_q, scnt_d;
  logic [2:0] bcnt_q, bcnt_d;
  logic [7:0] shreg_q, shreg_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       rda_q, rda_d;
  logic       frame_err_q, frame_err_d;
  logic       overrun_q, overrun_d;

  logic rxs;
  logic tick;
  logic realign;
  logic mid_start;
  logic bit_end;

  spart_baud_tick #(
    .DIV_W (DIV_W)
  ) u_tick (
    .clk     (clk),
    .rst     (rst),
    .divisor (bus.divisor),
    .realign (realign),
    .tick    (tick)
  );

  assign rxs       = sync_q[1];
  assign mid_start = tick && (scnt_q == PRE_MID);
  assign bit_end   = tick && (scnt_q == LAST_CNT);

  // Two-flop synchroniser on the asynchronous serial line.
  always_comb begin
    sync_d = {sync_q[0], rxd};
  end

  // Synchroniser register; idles high so reset never looks like a start bit.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= sync_d;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (!rxs) state_d = START;
      end
      START: begin
        if (mid_start) state_d = rxs ? IDLE : DATA;
      end
      DATA: begin
        if (bit_end && (bcnt_q == 3'd7)) state_d = STOP;
      end
      STOP: begin
        if (bit_end) state_d = rxs ? IDLE : BREAK;
      end
      BREAK: begin
        // A line held low must go high before another start is accepted.
        if (rxs) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: counters, shift register, received byte and status flags.
  always_comb begin
    scnt_d      = scnt_q;
    bcnt_d      = bcnt_q;
    shreg_d     = shreg_q;
    rx_data_d   = rx_data_q;
    realign     = 1'b0;
    // A read acknowledge clears all status; completions below override it.
    rda_d       = rda_q & ~bus.rd_ack;
    frame_err_d = frame_err_q & ~bus.rd_ack;
    overrun_d   = overrun_q & ~bus.rd_ack;

    if (tick && (state_q != IDLE) && (state_q != BREAK)) begin
      scnt_d = (scnt_q == LAST_CNT) ? 4'd0 : scnt_q + 4'd1;
    end

    case (state_q)
      IDLE: begin
        if (!rxs) begin
          scnt_d  = 4'd0;
          realign = 1'b1;
        end
      end
      START: begin
        if (mid_start && !rxs) begin
          scnt_d = 4'd0;
          bcnt_d = 3'd0;
        end
      end
      DATA: begin
        if (bit_end) begin
          // LSB arrives first, so shift right from the top.
          shreg_d = {rxs, shreg_q[7:1]};
          bcnt_d  = bcnt_q + 3'd1;
        end
      end
      STOP: begin
        if (bit_end) begin
          if (rxs) begin
            if (!rda_q || bus.rd_ack) begin
              rx_data_d = shreg_q;
              rda_d     = 1'b1;
            end else begin
              overrun_d = 1'b1;
            end
          end else begin
            frame_err_d = 1'b1;
          end
        end
      end
      default: begin
      end
    endcase
  end

  // Datapath registers; a reset abandons any frame in progress.
  always_ff @(posedge clk) begin
    if (!rst) begin
      scnt_q      <= 4'd0;
      bcnt_q      <= 3'd0;
      shreg_q     <= 8'h00;
      rx_data_q   <= 8'h00;
      rda_q       <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      scnt_q      <= scnt_d;
      bcnt_q      <= bcnt_d;
      shreg_q     <= shreg_d;
      rx_data_q   <= rx_data_d;
      rda_q       <= rda_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  assign bus.rx_data   = rx_data_q;
  assign bus.rda       = rda_q;
  assign bus.frame_err = frame_err_q;
  assign bus.overrun   = overrun_q;

endmodule

// File: doc/spart_rx.md
Name: spart_rx

Overview:
- Receive half of the SPART; sits directly downstream of the serial line (rxd) and upstream of the SPART bus interface that returns the received byte to the driver on an ioaddr 2'b00 read.
- Oversamples rxd at 16x the baud rate, validates the start bit and deserialises 8N1 frames, LSB first.
- Presents the byte on rx_data with the rda flag, which holds until the bus interface acknowledges the read.

Parameters:
OVERSAMPLE, 16, ticks per bit period
DIV_W, 16, width of baud divisor input

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-low reset
rxd  input  1  asynchronous serial input, idle high
divisor  input  DIV_W  baud tick divisor, driven from the bus-interface divisor registers
rd_ack  input  1  one-cycle pulse on a processor read of rx data; clears status
rx_data  output  8  last good received byte
rda  output  1  receive data available
frame_err  output  1  sticky: stop bit sampled low
overrun  output  1  sticky: byte completed while rda already set

Behaviour:
- One clock. Reset is synchronous and active-low: all state updates on posedge clk when rst==0.
- Reset values: rx_data=8'h00, rda=0, frame_err=0, overrun=0, FSM=IDLE, synchroniser flops=1, tick counter=divisor.
- A reset mid-frame abandons the frame with no flags set.
- Synchroniser: two flops on rxd. All logic uses only the second flop (rxs).
- Tick generator:
  - Down-counter; emits tick for one cycle when it reaches 0, then reloads divisor. Tick period is divisor+1 clocks, so divisor=0 gives a tick every clock.
  - The counter reloads (phase realign) on the IDLE->START transition.
- FSM states: IDLE, START, DATA, STOP, BREAK. The 4-bit sample counter scnt counts ticks; the 3-bit bit counter bcnt counts data bits.
- IDLE: when rxs==0, go to START and clear scnt.
- START: on each tick, scnt++. At the tick where scnt reaches OVERSAMPLE/2-1 (mid-bit):
  - rxs==1: false start, return to IDLE with no flags.
  - rxs==0: go to DATA with scnt=0, bcnt=0.
- DATA: on each tick, scnt++. On the tick where scnt wraps 15->0:
  - shift rxs into shreg MSB (right shift), so the first bit received ends up in bit 0;
  - bcnt++; after the 8th bit go to STOP.
- STOP: on the 16th tick (mid stop bit):
  - rxs==1: byte complete. If rda==0 or rd_ack this cycle: rx_data<=shreg, rda<=1. Otherwise overrun<=1, and rx_data and rda are unchanged (new byte discarded). Go to IDLE.
  - rxs==0: frame_err<=1, rx_data unchanged, go to BREAK.
- BREAK: wait for rxs==1, then go to IDLE. This prevents a held-low line from retriggering a start.
- rd_ack: clears rda, frame_err and overrun in the same cycle.
  - If a completion coincides with rd_ack, the completion wins: rda stays 1, rx_data takes the new byte, overrun is not set.
  - rd_ack while rda==0 is harmless.
- Latency: rda rises on the clock edge that samples the stop bit. Measured from the rxd falling edge, that is about 2 sync cycles plus 9.5 bit periods.
- Divisor changes take effect at the next counter reload. A change mid-frame is not supported, and the frame result is undefined.

Decomposition:
- spart_pkg holds:
  - typedef enum logic [2:0] rx_state_t {IDLE, START, DATA, STOP, BREAK};
  - localparams OVERSAMPLE=16 and MID_SAMPLE=OVERSAMPLE/2-1;
  - the default divisor constants matching the driver's br_cfg encodings.
- The tick generator is one natural sub-module, spart_baud_tick (clk, rst, divisor, realign, tick). The transmitter reuses it.

Test Plan:
- divisor=1 (tick every 2 clks, 32 clks/bit): drive frame 0xAB LSB first with a valid stop bit -> rx_data==8'hAB, rda==1, frame_err==0, overrun==0. Then pulse rd_ack -> rda==0.
- Two back-to-back frames 0xCD then 0x50 with no idle gap, rd_ack after each -> rx_data==8'hCD then 8'h50, no flags.
- Low glitch of 4 ticks on an idle line -> FSM returns to IDLE, rda stays 0, and a following 0x50 frame is received correctly.
- Frame 0x3C with stop bit low, line held low for 3 bit times -> frame_err==1, rda==0, no second frame detected until the line goes high.
- Frame 0x11 not acked, then frame 0x22 -> rx_data==8'h11, overrun==1. Next, rd_ack asserted on the exact completion cycle of 0x33 -> rx_data==8'h33, rda==1, overrun==0.
- rst low for 1 cycle in the middle of DATA bit 4 -> all outputs return to reset values, and the next full 0xAB frame is received correctly.
